// File: rtl/alu_pkg.sv
// Shared definitions for initiators of the 40-bit registered ALU.
// Holds the ALU opcode map, default widths, the response error codes
// and the state encoding of the command driver FSM.
package alu_pkg;

    localparam int WIDTH_DEF = 40;
    localparam int SEL_W_DEF = 5;

    // ALU select encodings. The ALU holds `out` on any select value
    // not listed here, so NOP is the safe idle value.
    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;

    // Response error codes.
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_check.sv
// Combinational command filter for ALU initiators.
// Ports:
//   op       in   SEL_W  requested opcode
//   b        in   WIDTH  operand b (divisor for DIV)
//   legal    out  1      op is one of ADD/SUB/MUL/DIV
//   div_zero out  1      op is DIV and b is zero
//   err_code out  2      ERR_OK / ERR_ILLEGAL / ERR_DIV0
// NOP is not accepted as a command: issuing it would only hand back a
// stale ALU result, so it is reported as an illegal opcode.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [SEL_W-1:0] op,
    input  logic [WIDTH-1:0] b,
    output logic             legal,
    output logic             div_zero,
    output logic [1:0]       err_code
);

    always_comb begin
        legal    = (op == SEL_W'(OP_ADD)) || (op == SEL_W'(OP_SUB)) ||
                   (op == SEL_W'(OP_MUL)) || (op == SEL_W'(OP_DIV));
        div_zero = (op == SEL_W'(OP_DIV)) && (b == '0);
        if (!legal) begin
            err_code = ERR_ILLEGAL;
        end else if (div_zero) begin
            err_code = ERR_DIV0;
        end else begin
            err_code = ERR_OK;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command driver for the 40-bit registered ALU.
// Accepts one command at a time on cmd_* (valid/ready), drives alu_a/
// alu_b/alu_sel, waits out the ALU latency, captures alu_out and returns
// a tagged result on rsp_* (valid/ready). Illegal opcodes and divide by
// zero are answered locally without touching the ALU.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; a source holds its payload stable while valid is high
// and ready is low, and valid never drops before the transfer.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/ready/op/a/b/tag       command channel
//   alu_a, alu_b, alu_sel, alu_out   ALU connection
//   rsp_valid/ready/data/tag/err     response channel
//   busy                             FSM not in IDLE
//   cmd_count, err_count             saturating statistics
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int LAT_W = $clog2(ALU_LAT + 2);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cmd_count_q, cmd_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               op_legal;
    logic               op_div_zero;
    logic [1:0]         op_err_code;
    logic               accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    alu_op_check #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_op_check (
        .op       (cmd_op),
        .b        (cmd_b),
        .legal    (op_legal),
        .div_zero (op_div_zero),
        .err_code (op_err_code)
    );

    // rst_n is folded in so no command is taken while reset is held.
    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_tag_d   = cmd_tag;
                    cmd_count_d = sat_inc(cmd_count_q);
                    if (!op_legal || op_div_zero) begin
                        // Answered locally; the ALU keeps seeing NOP.
                        rsp_err_d   = op_err_code;
                        rsp_data_d  = op_div_zero ? '1 : '0;
                        rsp_valid_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        state_d     = ST_RESP;
                    end else begin
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                        alu_sel_d = cmd_op;
                        lat_cnt_d = LAT_W'(ALU_LAT + 1);
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Operands stay put; the ALU re-sampling them is harmless.
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    rsp_data_d  = alu_out;
                    rsp_err_d   = ERR_OK;
                    rsp_valid_d = 1'b1;
                    alu_sel_d   = SEL_W'(OP_NOP);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= SEL_W'(OP_NOP);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= ERR_OK;
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_count = cmd_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a small registered ALU model.
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_alu_cmd_driver;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [39:0] cmd_a;
    logic [39:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic [39:0] alu_a;
    logic [39:0] alu_b;
    logic [4:0]  alu_sel;
    logic [39:0] alu_out = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [39:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [15:0] cmd_count;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    alu_cmd_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .cmd_count (cmd_count),
        .err_count (err_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU model: samples a/b/s every edge, holds on unknown selects.
    always @(posedge clk) begin
        case (alu_sel)
            5'b00101: alu_out <= alu_a + alu_b;
            5'b00110: alu_out <= alu_a - alu_b;
            5'b01000: alu_out <= alu_a * alu_b;
            5'b01011: if (alu_b != '0) alu_out <= alu_a / alu_b;
            default:  alu_out <= alu_out;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Issue one command from IDLE and wait (bounded) for rsp_valid.
    // k = number of rising edges after the accept edge at which rsp_valid
    // was set (0 = set on the accept edge itself).
    task automatic send(input logic [4:0] op, input logic [39:0] a, input logic [39:0] b,
                        input logic [3:0] tag, output int k, output logic sel_seen);
        chk("acc_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        sel_seen = (alu_sel != 5'b0);
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (alu_sel != 5'b0) sel_seen = 1'b1;
        end
        chk("rsp_wait_bound", 64'(k < 20), 64'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hs_valid_low", 64'(rsp_valid), 64'd0);
        chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("hs_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int   k;
        logic seen;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_sel", 64'(alu_sel), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_cmd_count", 64'(cmd_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Illegal opcode 00111
        send(5'b00111, 40'h0B, 40'h03, 4'h5, k, seen);
        chk("ill_latency", 64'(k), 64'd0);
        chk("ill_err", 64'(rsp_err), 64'd1);
        chk("ill_data", 64'(rsp_data), 64'd0);
        chk("ill_tag", 64'(rsp_tag), 64'h5);
        chk("ill_sel_quiet", 64'(seen), 64'd0);
        chk("ill_cmd_count", 64'(cmd_count), 64'd1);
        chk("ill_err_count", 64'(err_count), 64'd1);
        take_rsp();

        // DIV by zero
        send(5'b01011, 40'h0B, 40'h00, 4'h6, k, seen);
        chk("dz_latency", 64'(k), 64'd0);
        chk("dz_err", 64'(rsp_err), 64'd2);
        chk("dz_data", 64'(rsp_data), 64'hFF_FFFF_FFFF);
        chk("dz_tag", 64'(rsp_tag), 64'h6);
        chk("dz_sel_quiet", 64'(seen), 64'd0);
        chk("dz_cmd_count", 64'(cmd_count), 64'd2);
        chk("dz_err_count", 64'(err_count), 64'd2);
        take_rsp();

        // ADD 0x0B + 0x03
        send(5'b00101, 40'h0B, 40'h03, 4'h1, k, seen);
        chk("add_latency", 64'(k), 64'd2);
        chk("add_data", 64'(rsp_data), 64'h0E);
        chk("add_tag", 64'(rsp_tag), 64'h1);
        chk("add_err", 64'(rsp_err), 64'd0);
        chk("add_sel_issued", 64'(seen), 64'd1);
        chk("add_sel_back_nop", 64'(alu_sel), 64'd0);
        take_rsp();

        // SUB wraps
        send(5'b00110, 40'h03, 40'h0B, 4'h2, k, seen);
        chk("sub_latency", 64'(k), 64'd2);
        chk("sub_data", 64'(rsp_data), 64'hFF_FFFF_FFF8);
        chk("sub_tag", 64'(rsp_tag), 64'h2);
        chk("sub_err", 64'(rsp_err), 64'd0);
        take_rsp();

        // MUL
        send(5'b01000, 40'h0B, 40'h03, 4'h3, k, seen);
        chk("mul_data", 64'(rsp_data), 64'h21);
        chk("mul_tag", 64'(rsp_tag), 64'h3);
        take_rsp();

        // DIV truncates
        send(5'b01011, 40'h0B, 40'h03, 4'h4, k, seen);
        chk("div_data", 64'(rsp_data), 64'h03);
        chk("div_err", 64'(rsp_err), 64'd0);
        chk("div_tag", 64'(rsp_tag), 64'h4);
        chk("div_cmd_count", 64'(cmd_count), 64'd6);
        chk("div_err_count", 64'(err_count), 64'd2);
        take_rsp();

        // Back-pressure: rsp_ready low for 5 cycles
        send(5'b00101, 40'h10, 40'h20, 4'h7, k, seen);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'h30);
            chk("bp_tag", 64'(rsp_tag), 64'h7);
            chk("bp_err", 64'(rsp_err), 64'd0);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        take_rsp();

        // Reset during WAIT
        cmd_valid = 1'b1;
        cmd_op    = 5'b00101;
        cmd_a     = 40'h0B;
        cmd_b     = 40'h03;
        cmd_tag   = 4'h9;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mr_busy", 64'(busy), 64'd1);
        chk("mr_sel_issued", 64'(alu_sel), 64'h05);
        rst_n = 1'b0;
        #1;
        chk("mr_sel_async_nop", 64'(alu_sel), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_cmd_count", 64'(cmd_count), 64'd0);
        chk("mr_err_count", 64'(err_count), 64'd0);
        chk("mr_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mr_cmd_ready_after", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
        end
        chk("mr_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
